// File: rtl/rr_grant_ctrl_8.sv
// rr_grant_ctrl_8 - round-robin arbiter for one shared 8-way one-hot resource.
//
// A rotating priority pointer picks the first active requester at or after
// the pointer (wrapping 7->0). A grant is held while the grantee keeps its
// request, for at most MAX_HOLD cycles (0 = no limit). On release the pointer
// moves just past the grantee, and the block re-arbitrates on the same edge,
// so back-to-back grants need no idle cycle.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req[N-1:0]   level-sensitive request vector
//   grant        registered one-hot grant, zero when idle
//   grant_idx    registered index of the grantee (meaningful when grant_valid)
//   grant_valid  a grant is active
//   hold_cnt     cycles spent in the current grant, 0-based
module rr_grant_ctrl_8 #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic [IDX_W+1:0] hold_cnt
);

    localparam int CW          = IDX_W + 2;
    localparam int HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [CW-1:0] HOLD_LAST = HOLD_LAST_I[CW-1:0];

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] arb_ptr;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;
    logic [N-1:0]     win_oh;
    logic             hold;

    // In GRANT the only arbitration that matters is the one at release, whose
    // search starts just past the grantee; that is also the pointer we store.
    always_comb begin
        arb_ptr = (state == GRANT) ? grant_idx + IDX_W'(1) : ptr;
    end

    // Scan from the farthest offset down so the nearest active requester
    // (lowest offset from arb_ptr) is the last assignment and wins.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = arb_ptr + IDX_W'(k);
            if (req[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dec
            assign win_oh[gi] = (win_idx == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        hold = req[grant_idx] && ((MAX_HOLD == 0) || (hold_cnt < HOLD_LAST));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        state       <= GRANT;
                        grant       <= win_oh;
                        grant_idx   <= win_idx;
                        grant_valid <= 1'b1;
                        hold_cnt    <= '0;
                    end
                end
                GRANT: begin
                    if (hold) begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end else begin
                        // Release: grantee dropped or hit the hold limit.
                        ptr <= arb_ptr;
                        if (win_any) begin
                            grant     <= win_oh;
                            grant_idx <= win_idx;
                            hold_cnt  <= '0;
                        end else begin
                            state       <= IDLE;
                            grant       <= '0;
                            grant_valid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
